sram_dp: RTL and testbench

SRAM_DP -- requirements
Module: sram_dp

---
 rtl/sram_pkg.sv | 13 +
 rtl/sram_rd_pipe.sv | 66 ++++++
 rtl/sram_dp.sv | 107 ++++++++++
 tb/tb_sram_dp.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and helpers for the dual-port SRAM
package sram_pkg;

    // Same-address behaviour when port 0 writes the word port 1 is reading
    localparam int RDW_READ_FIRST    = 0;
    localparam int RDW_WRITE_THROUGH = 1;

    // One mask bit per byte lane of a data word
    function automatic int mask_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - read data/valid/collision stage with optional output register
module sram_rd_pipe #(
    parameter int DW      = 32,
    parameter int OUT_REG = 0
) (
    input  logic          Clk,
    input  logic          Rstn,
    input  logic          rd_valid,
    input  logic [DW-1:0] rd_data,
    input  logic          rd_coll,
    output logic [DW-1:0] dout,
    output logic          dvalid,
    output logic          coll
);

    logic [DW-1:0] s1_data;
    logic          s1_valid;
    logic          s1_coll;

    // First stage: capture the array word; data holds until the next read
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_coll  <= 1'b0;
        end else begin
            s1_valid <= rd_valid;
            s1_coll  <= rd_valid & rd_coll;
            if (rd_valid) begin
                s1_data <= rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] s2_data;
            logic          s2_valid;
            logic          s2_coll;

            // Second stage: same hold/pulse behaviour, one edge later
            always_ff @(posedge Clk or negedge Rstn) begin
                if (!Rstn) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                    s2_coll  <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_coll  <= s1_coll;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign dout   = s2_data;
            assign dvalid = s2_valid;
            assign coll   = s2_coll;
        end else begin : g_no_out_reg
            assign dout   = s1_data;
            assign dvalid = s1_valid;
            assign coll   = s1_coll;
        end
    endgenerate

endmodule

// File: rtl/sram_dp.sv
// rtl/sram_dp.sv - one read/write plus one read-only port SRAM with byte mask
module sram_dp
    import sram_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 9,
    parameter int RAM_DEPTH = 1 << AW,
    parameter int OUT_REG   = 0,
    parameter int RDW_MODE  = RDW_READ_FIRST
) (
    input  logic                   Clk,
    input  logic                   Rstn,
    input  logic                   Csb0,
    input  logic                   Web0,
    input  logic [mask_w(DW)-1:0]  Wmask0,
    input  logic [AW-1:0]          ADDR0,
    input  logic [DW-1:0]          DIN0,
    output logic [DW-1:0]          DOUT0,
    output logic                   Dvalid0,
    input  logic                   Csb1,
    input  logic [AW-1:0]          ADDR1,
    output logic [DW-1:0]          DOUT1,
    output logic                   Dvalid1,
    output logic                   Collision
);

    localparam int          MW      = mask_w(DW);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(RAM_DEPTH);

    logic [DW-1:0] mem [RAM_DEPTH];

    logic          wr0, rd0, rd1;
    logic          in0, in1;
    logic          wr_en;
    logic          coll_now;
    logic [DW-1:0] rd0_word, rd1_word;
    logic          coll0_unused_free, coll1;

    assign wr0 = !Csb0 && !Web0;
    assign rd0 = !Csb0 && Web0;
    assign rd1 = !Csb1;

    // Depth may be a non-power-of-two; addresses past the end are dead space
    assign in0 = {1'b0, ADDR0} < DEPTH_L;
    assign in1 = {1'b0, ADDR1} < DEPTH_L;

    // Writes are held off for as long as reset is asserted
    assign wr_en    = Rstn && wr0 && in0;
    assign coll_now = wr0 && rd1 && (ADDR0 == ADDR1);

    // Masked byte write into the array (array contents are never reset)
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int i = 0; i < MW; i++) begin
                if (Wmask0[i]) begin
                    mem[ADDR0][8*i +: 8] <= DIN0[8*i +: 8];
                end
            end
        end
    end

    // Array lookup for both ports, with write-through merge on a collision
    always_comb begin
        rd0_word = '0;
        rd1_word = '0;
        if (in0) begin
            rd0_word = mem[ADDR0];
        end
        if (in1) begin
            rd1_word = mem[ADDR1];
            if (RDW_MODE == RDW_WRITE_THROUGH && coll_now) begin
                for (int i = 0; i < MW; i++) begin
                    if (Wmask0[i]) begin
                        rd1_word[8*i +: 8] = DIN0[8*i +: 8];
                    end
                end
            end
        end
    end

    sram_rd_pipe #(.DW(DW), .OUT_REG(OUT_REG)) u_pipe0 (
        .Clk      (Clk),
        .Rstn     (Rstn),
        .rd_valid (rd0),
        .rd_data  (rd0_word),
        .rd_coll  (1'b0),
        .dout     (DOUT0),
        .dvalid   (Dvalid0),
        .coll     (coll0_unused_free)
    );

    sram_rd_pipe #(.DW(DW), .OUT_REG(OUT_REG)) u_pipe1 (
        .Clk      (Clk),
        .Rstn     (Rstn),
        .rd_valid (rd1),
        .rd_data  (rd1_word),
        .rd_coll  (coll_now),
        .dout     (DOUT1),
        .dvalid   (Dvalid1),
        .coll     (coll1)
    );

    // Port 0 never tags a collision, so its flag is constant 0; both pipes
    // share one latency so the OR stays aligned with Dvalid1
    assign Collision = coll1 | coll0_unused_free;

endmodule

// File: tb/tb_sram_dp.sv
// tb/tb_sram_dp.sv - randomized self-checking bench for sram_dp against a memory model
module tb_sram_dp;

    logic        Clk, Rstn;
    logic        Csb0, Web0, Csb1;
    logic [3:0]  Wmask0;
    logic [8:0]  ADDR0, ADDR1;
    logic [31:0] DIN0;

    logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
    logic        a_dv0, a_dv1, a_coll, b_dv0, b_dv1, b_coll;

    // Instance A: full depth, no output register, read-first
    sram_dp #(.DW(32), .AW(9), .OUT_REG(0), .RDW_MODE(0)) u_a (
        .Clk(Clk), .Rstn(Rstn), .Csb0(Csb0), .Web0(Web0), .Wmask0(Wmask0),
        .ADDR0(ADDR0), .DIN0(DIN0), .DOUT0(a_dout0), .Dvalid0(a_dv0),
        .Csb1(Csb1), .ADDR1(ADDR1), .DOUT1(a_dout1), .Dvalid1(a_dv1),
        .Collision(a_coll)
    );

    // Instance B: depth 400, output register, write-through
    sram_dp #(.DW(32), .AW(9), .RAM_DEPTH(400), .OUT_REG(1), .RDW_MODE(1)) u_b (
        .Clk(Clk), .Rstn(Rstn), .Csb0(Csb0), .Web0(Web0), .Wmask0(Wmask0),
        .ADDR0(ADDR0), .DIN0(DIN0), .DOUT0(b_dout0), .Dvalid0(b_dv0),
        .Csb1(Csb1), .ADDR1(ADDR1), .DOUT1(b_dout1), .Dvalid1(b_dv1),
        .Collision(b_coll)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [31:0] ma [512];
    logic [31:0] mb [512];

    logic [31:0] e_a_d0, e_a_d1, e_b_d0, e_b_d1;
    logic        e_a_v0, e_a_v1, e_a_c, e_b_v0, e_b_v1, e_b_c;
    logic [31:0] p_d0, p_d1;
    logic        p_v0, p_v1, p_c;

    logic [133:0] obs_vec, exp_vec;
    assign obs_vec = {a_dout0, a_dv0, a_dout1, a_dv1, a_coll,
                      b_dout0, b_dv0, b_dout1, b_dv1, b_coll};
    assign exp_vec = {e_a_d0, e_a_v0, e_a_d1, e_a_v1, e_a_c,
                      e_b_d0, e_b_v0, e_b_d1, e_b_v1, e_b_c};

    task automatic clear_model();
        e_a_d0 = '0; e_a_v0 = 0; e_a_d1 = '0; e_a_v1 = 0; e_a_c = 0;
        e_b_d0 = '0; e_b_v0 = 0; e_b_d1 = '0; e_b_v1 = 0; e_b_c = 0;
        p_d0 = '0; p_v0 = 0; p_d1 = '0; p_v1 = 0; p_c = 0;
    endtask

    // Drive one command at a falling edge, advance the model, return at the next falling edge
    task automatic step(input bit c0, input bit w0, input logic [3:0] m, input logic [8:0] a0,
                        input logic [31:0] d, input bit c1, input logic [8:0] a1);
        bit wr, rd0, rd1, coll;
        logic [31:0] fa0, fa1, fb0, fb1;
        Csb0 = c0; Web0 = w0; Wmask0 = m; ADDR0 = a0; DIN0 = d; Csb1 = c1; ADDR1 = a1;
        wr   = !c0 && !w0;
        rd0  = !c0 && w0;
        rd1  = !c1;
        coll = wr && rd1 && (a0 == a1);
        fa0  = ma[a0];
        fa1  = ma[a1];
        fb0  = (a0 < 400) ? mb[a0] : 32'h0;
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    ma[a0][8*i +: 8] = d[8*i +: 8];
                    if (a0 < 400) mb[a0][8*i +: 8] = d[8*i +: 8];
                end
            end
        end
        // Write-through port sees the word as it stands after this write
        fb1 = (a1 < 400) ? mb[a1] : 32'h0;
        @(posedge Clk);
        if (rd0) e_a_d0 = fa0;
        if (rd1) e_a_d1 = fa1;
        e_a_v0 = rd0; e_a_v1 = rd1; e_a_c = coll;
        if (p_v0) e_b_d0 = p_d0;
        if (p_v1) e_b_d1 = p_d1;
        e_b_v0 = p_v0; e_b_v1 = p_v1; e_b_c = p_c;
        p_d0 = fb0; p_v0 = rd0; p_d1 = fb1; p_v1 = rd1; p_c = coll;
        @(negedge Clk);
        cyc++;
    endtask

    task automatic test_reset();
        clear_model();
        Csb0 = 1; Web0 = 1; Wmask0 = 0; ADDR0 = 0; DIN0 = 0; Csb1 = 1; ADDR1 = 0;
        Rstn = 1'b1;
        #1 Rstn = 1'b0;
        #1;
        n_total++;
        if (obs_vec !== 134'b0) begin
            n_bad++;
            $display("FAIL reset_state got=%h want=0", obs_vec);
        end
        @(negedge Clk);
        @(negedge Clk);
        Rstn = 1'b1;
    endtask

    task automatic test_init();
        for (int i = 0; i < 512; i++) begin
            step(0, 0, 4'hF, 9'(i), 32'h0, 1, 9'd0);
            n_total++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL init cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_write_read();
        step(0, 0, 4'hF, 9'h005, 32'hDEADBEEF, 1, 9'd0);
        step(0, 1, 4'h0, 9'h005, 32'h0, 1, 9'd0);
        n_total++;
        if (obs_vec !== exp_vec || a_dout0 !== 32'hDEADBEEF || a_dv0 !== 1'b1) begin
            n_bad++;
            $display("FAIL write_read got=%h/%b want=deadbeef/1", a_dout0, a_dv0);
        end
        step(1, 1, 4'h0, 9'h0, 32'h0, 1, 9'd0);
        n_total++;
        if (obs_vec !== exp_vec || a_dv0 !== 1'b0 || a_dout0 !== 32'hDEADBEEF
            || b_dout0 !== 32'hDEADBEEF || b_dv0 !== 1'b1) begin
            n_bad++;
            $display("FAIL read_hold got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_mask();
        step(0, 0, 4'h5, 9'h005, 32'h11223344, 1, 9'd0);
        step(1, 1, 4'h0, 9'h0, 32'h0, 0, 9'h005);
        n_total++;
        if (obs_vec !== exp_vec || a_dout1 !== 32'hDE22BE44 || a_dv1 !== 1'b1) begin
            n_bad++;
            $display("FAIL byte_mask got=%h want=de22be44", a_dout1);
        end
        step(0, 0, 4'h0, 9'h005, 32'hFFFFFFFF, 1, 9'd0);
        step(0, 1, 4'h0, 9'h005, 32'h0, 1, 9'd0);
        n_total++;
        if (obs_vec !== exp_vec || a_dout0 !== 32'hDE22BE44) begin
            n_bad++;
            $display("FAIL zero_mask got=%h want=de22be44", a_dout0);
        end
    endtask

    task automatic test_collision();
        step(0, 0, 4'hF, 9'h010, 32'hCAFEF00D, 0, 9'h010);
        n_total++;
        if (obs_vec !== exp_vec || a_dout1 !== 32'h0 || a_coll !== 1'b1 || a_dv1 !== 1'b1) begin
            n_bad++;
            $display("FAIL coll_read_first got=%h c=%b want=0 c=1", a_dout1, a_coll);
        end
        step(1, 1, 4'h0, 9'h0, 32'h0, 1, 9'd0);
        n_total++;
        if (obs_vec !== exp_vec || b_dout1 !== 32'hCAFEF00D || b_coll !== 1'b1
            || b_dv1 !== 1'b1 || a_coll !== 1'b0) begin
            n_bad++;
            $display("FAIL coll_write_through got=%h c=%b want=cafef00d c=1", b_dout1, b_coll);
        end
    endtask

    task automatic test_burst();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(0, 1, 4'h0, 9'(i), 32'h0, 0, 9'(7 - i));
            else       step(1, 1, 4'h0, 9'h0, 32'h0, 1, 9'd0);
            n_total++;
            if (obs_vec !== exp_vec || b_dv0 !== (i >= 1 && i <= 8)) begin
                n_bad++;
                $display("FAIL burst i=%0d got=%h want=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_out_of_range();
        step(0, 0, 4'hF, 9'd450, 32'h5A5A5A5A, 1, 9'd0);
        step(0, 1, 4'h0, 9'd450, 32'h0, 0, 9'd450);
        n_total++;
        if (obs_vec !== exp_vec || a_dout0 !== 32'h5A5A5A5A) begin
            n_bad++;
            $display("FAIL oor_full got=%h want=%h", obs_vec, exp_vec);
        end
        step(1, 1, 4'h0, 9'h0, 32'h0, 1, 9'd0);
        n_total++;
        if (obs_vec !== exp_vec || b_dout0 !== 32'h0 || b_dv0 !== 1'b1 || b_dv1 !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_short got=%h/%b want=0/1", b_dout0, b_dv0);
        end
    endtask

    task automatic test_random();
        logic [8:0] a0, a1;
        for (int i = 0; i < 400; i++) begin
            a0 = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(390, 415)) : 9'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 2) == 0) ? a0 : 9'($urandom_range(0, 15));
            step(1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), a0, $urandom,
                 1'($urandom_range(0, 3) == 0), a1);
            n_total++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_inflight();
        Csb0 = 0; Web0 = 1; ADDR0 = 9'h005; Csb1 = 0; ADDR1 = 9'h010;
        @(posedge Clk);
        Csb0 = 1; Csb1 = 1;
        #2 Rstn = 1'b0;
        #1;
        n_total++;
        if (obs_vec !== 134'b0) begin
            n_bad++;
            $display("FAIL inflight_clear got=%h want=0", obs_vec);
        end
        Csb0 = 0; Web0 = 0; Wmask0 = 4'hF; ADDR0 = 9'h005; DIN0 = 32'hFFFFFFFF;
        @(negedge Clk);
        @(negedge Clk);
        clear_model();
        Rstn = 1'b1;
        step(0, 0, 4'hF, 9'h030, 32'h0BADF00D, 1, 9'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 4'h0, 9'h0, 32'h0, 1, 9'd0);
            n_total++;
            if (obs_vec !== exp_vec || a_dv0 !== 1'b0 || b_dv0 !== 1'b0 || b_dv1 !== 1'b0) begin
                n_bad++;
                $display("FAIL inflight_dropped i=%0d got=%h want=%h", i, obs_vec, exp_vec);
            end
        end
        step(0, 1, 4'h0, 9'h005, 32'h0, 0, 9'h030);
        step(1, 1, 4'h0, 9'h0, 32'h0, 1, 9'd0);
        n_total++;
        if (obs_vec !== exp_vec || b_dout0 === 32'hFFFFFFFF || b_dout1 !== 32'h0BADF00D) begin
            n_bad++;
            $display("FAIL mem_kept got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_mask();
        test_collision();
        test_burst();
        test_out_of_range();
        test_random();
        test_reset_inflight();
        test_burst();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
